score_matmul: RTL and testbench
===============================

// Module: score_matmul
// PURPOSE
//  Attention-score stage directly downstream of the QKV projection engine.
//  Reads Q (N x D) and K (N x D) from result SRAM and computes S = Q * K^T (N x N).
//  Writes S back into result SRAM directly after the Q/K/V region.
//  One Q row is cached locally; K rows are then streamed against it.
//  Kicked off by the top-level sequencer once the projection engine returns dut_ready.
// PARAMETERS
//  ADDR_W   16  result SRAM address width
//  DATA_W   32  element / accumulator width
//  MAX_DIM  64  depth of the Q-row buffer; largest supported emb_dim
// PORTS
//  clk                 in   1       clock
//  reset_n             in   1       synchronous, active-low reset
//  start               in   1       one-cycle request; dims sampled in the same cycle
//  seq_len             in   16      N, number of tokens (rows of Q/K)
//  emb_dim             in   16      D, embedding width (cols of Q/K)
//  busy                out  1       high from the cycle after accepted start through DONE
//  done                out  1       one-cycle pulse when S is fully written
//  err                 out  1       sticky until next start: emb_dim > MAX_DIM
//  res_read_address    out  ADDR_W  result SRAM read address
//  res_read_data       in   DATA_W  read data, valid 1 cycle after address
//  res_write_enable    out  1       result SRAM write strobe
//  res_write_address   out  ADDR_W  result SRAM write address
//  res_write_data      out  DATA_W  result SRAM write data
// BEHAVIOUR
//  Memory map (row-major, one element per word):
//   - Q_BASE = 0
//   - K_BASE = N*D
//   - S_BASE = 3*N*D (V at 2*N*D is untouched)
//  Reset: state IDLE; busy=done=err=0; res_write_enable=0; all addresses/data=0; acc=0.
//  States:
//   IDLE: start=1 latches N,D.
//    - N==0 or D==0: DONE next cycle, no writes.
//    - D>MAX_DIM: err=1, DONE next cycle, no writes.
//    - otherwise LOADQ with i=0.
//    - start while busy is ignored.
//   LOADQ: D cycles; cycle k issues Q_BASE+i*D+k.
//    - Data is captured into qbuf[k] one cycle later.
//    - After k=D-1 go to KSTREAM with j=0.
//   KSTREAM: D cycles; cycle k issues K_BASE+j*D+k.
//    - When data arrives (next cycle), acc <= acc + data*qbuf[k].
//    - acc clears at KSTREAM entry.
//   WRITE: 1 cycle; last product arrives.
//    - res_write_enable=1, address S_BASE+i*N+j, data = acc + data*qbuf[D-1].
//    - Then: j<N-1 -> KSTREAM(j+1); else i<N-1 -> LOADQ(i+1); else DONE.
//   DONE: done=1 for one cycle; busy=0; return to IDLE.
//  Arithmetic: products and sums are modulo 2^DATA_W (unsigned, wrap, no saturation).
//  Address arithmetic is modulo 2^ADDR_W.
//  Latency: done is high in cycle N*D + N*N*(D+1) + 1 after the start cycle.
//  Writes occur only in WRITE; exactly N*N writes per run, in S row-major order.
//  res_write_data is 0 whenever res_write_enable is 0.
//  Reset mid-run: abort immediately to IDLE, no further writes, done not pulsed.
//  Back-to-back: start in the cycle after done is accepted.
// TESTING
//  - N=2,D=2, Q=[[1,2],[3,4]], K=[[5,6],[7,8]]
//    -> writes 17,23,39,53 to addr 12..15; done in cycle 17 after start.
//  - N=1,D=1, Q=3, K=0xFFFFFFFF -> addr 3 = 0xFFFFFFFD (wrap); exactly one write.
//  - N=0 or D=0 -> done next cycle; zero writes; err=0.
//  - D=MAX_DIM+1 -> err=1, done next cycle, no writes.
//  - D=MAX_DIM, all ones -> every S entry = MAX_DIM.
//  - start during busy ignored; reset_n low mid-KSTREAM
//    -> next cycle IDLE, busy=0, no write, no done.

Source files
------------

// File: rtl/score_matmul.sv
// rtl/score_matmul.sv - attention score stage computing S = Q * K^T from result SRAM
module score_matmul #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [15:0]       i_seq_len,
  input  logic [15:0]       i_emb_dim,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_res_read_address,
  input  logic [DATA_W-1:0] i_res_read_data,
  output logic              o_res_write_enable,
  output logic [ADDR_W-1:0] o_res_write_address,
  output logic [DATA_W-1:0] o_res_write_data
);

  localparam int QW = $clog2(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADQ   = 3'd1,
    S_KSTREAM = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_n;
  logic [15:0]       r_d;
  logic [15:0]       r_i;
  logic [15:0]       r_j;
  logic [15:0]       r_k;
  logic [ADDR_W-1:0] r_nd;
  logic [DATA_W-1:0] r_acc;
  logic              r_err;
  logic              r_cap_valid;
  logic [QW-1:0]     r_cap_idx;
  logic [DATA_W-1:0] r_qbuf [0:MAX_DIM-1];

  logic              w_k_last;
  logic              w_reject;
  logic [QW-1:0]     w_qidx;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_acc_next;
  logic [ADDR_W-1:0] w_q_addr;
  logic [ADDR_W-1:0] w_k_addr;
  logic [ADDR_W-1:0] w_s_addr;

  assign w_k_last = (r_k == r_d - 16'd1);
  assign w_reject = (i_seq_len == 16'd0) || (i_emb_dim == 16'd0) || (i_emb_dim > 16'(MAX_DIM));

  // The product arriving in WRITE belongs to the last column; in KSTREAM it lags the issued column by one.
  assign w_qidx     = (r_state == S_WRITE) ? QW'(r_d - 16'd1) : QW'(r_k - 16'd1);
  assign w_prod     = DATA_W'(i_res_read_data * r_qbuf[w_qidx]);
  assign w_acc_next = r_acc + w_prod;

  assign w_q_addr = ADDR_W'(r_i * r_d) + ADDR_W'(r_k);
  assign w_k_addr = r_nd + ADDR_W'(r_j * r_d) + ADDR_W'(r_k);
  assign w_s_addr = r_nd + r_nd + r_nd + ADDR_W'(r_i * r_n) + ADDR_W'(r_j);
  assign o_err    = r_err;

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and SRAM/handshake outputs, decoded from the current state.
  always_comb begin
    w_next              = r_state;
    o_busy              = 1'b0;
    o_done              = 1'b0;
    o_res_read_address  = '0;
    o_res_write_enable  = 1'b0;
    o_res_write_address = '0;
    o_res_write_data    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = w_reject ? S_DONE : S_LOADQ;
      end
      S_LOADQ: begin
        o_busy             = 1'b1;
        o_res_read_address = w_q_addr;
        if (w_k_last) w_next = S_KSTREAM;
      end
      S_KSTREAM: begin
        o_busy             = 1'b1;
        o_res_read_address = w_k_addr;
        if (w_k_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_busy              = 1'b1;
        o_res_write_enable  = 1'b1;
        o_res_write_address = w_s_addr;
        o_res_write_data    = w_acc_next;
        if (r_j < r_n - 16'd1)      w_next = S_KSTREAM;
        else if (r_i < r_n - 16'd1) w_next = S_LOADQ;
        else                        w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Loop counters, dimension latches, accumulator and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_n         <= '0;
      r_d         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_nd        <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_idx   <= '0;
    end else begin
      r_cap_valid <= (r_state == S_LOADQ);
      r_cap_idx   <= QW'(r_k);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_n   <= i_seq_len;
            r_d   <= i_emb_dim;
            r_nd  <= ADDR_W'(i_seq_len * i_emb_dim);
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_err <= (i_seq_len != 16'd0) && (i_emb_dim > 16'(MAX_DIM));
          end
        end
        S_LOADQ: begin
          r_k <= w_k_last ? 16'd0 : r_k + 16'd1;
        end
        S_KSTREAM: begin
          r_k   <= w_k_last ? 16'd0 : r_k + 16'd1;
          r_acc <= (r_k == 16'd0) ? '0 : w_acc_next;
        end
        S_WRITE: begin
          if (r_j < r_n - 16'd1) begin
            r_j <= r_j + 16'd1;
          end else begin
            r_j <= '0;
            r_i <= r_i + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Q-row cache: read data lands one cycle after the LOADQ address was issued.
  always_ff @(posedge clk) begin
    if (r_cap_valid) r_qbuf[r_cap_idx] <= i_res_read_data;
  end

endmodule

// File: tb/tb_score_matmul.sv
// tb/tb_score_matmul.sv - scoreboard bench for score_matmul
module tb_score_matmul;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MD = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [15:0]   seq_len;
  logic [15:0]   emb_dim;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] mem [0:65535];
  logic [47:0]   exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            n_writes = 0;

  always #5 clk = ~clk;

  score_matmul #(.ADDR_W(AW), .DATA_W(DW), .MAX_DIM(MD)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start), .i_seq_len(seq_len), .i_emb_dim(emb_dim),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_res_read_address(raddr), .i_res_read_data(rdata),
    .o_res_write_enable(we), .o_res_write_address(waddr), .o_res_write_data(wdata)
  );

  always @(posedge clk) rdata <= mem[raddr];

  always @(negedge clk) begin
    logic [47:0] e;
    if (we === 1'b1) begin
      n_writes++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0d data=%0h expected no write", waddr, wdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({waddr, wdata} === e) else begin
          errors++;
          $error("FAIL write observed addr=%0d data=%0h expected addr=%0d data=%0h", waddr, wdata, e[47:32], e[31:0]);
        end
      end
    end else if (reset_n === 1'b1) begin
      checks++;
      assert (wdata === '0) else begin
        errors++;
        $error("FAIL idle_wdata observed=%0h expected=0", wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input int n, input int d);
    logic [DW-1:0] acc;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = '0;
        for (int k = 0; k < d; k++) acc = acc + mem[i*d+k] * mem[n*d+j*d+k];
        exp_q.push_back({16'(3*n*d + i*n + j), acc});
      end
  endtask

  task automatic fill_random(input int n, input int d);
    for (int a = 0; a < 2*n*d; a++) mem[a] = $urandom;
  endtask

  task automatic run(input int n, input int d, input int lat, input logic e_err, input int e_writes, input bit poke);
    int cyc;
    int base;
    tick();
    seq_len = 16'(n);
    emb_dim = 16'(d);
    start   = 1'b1;
    base    = n_writes;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 5000) begin
      if (poke && cyc == 3) begin
        check("busy_mid_run", busy, 1'b1);
        start = 1'b1; seq_len = 16'd1; emb_dim = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_latency", cyc, lat);
    check("err_flag", err, e_err);
    tick();
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
    check("write_count", n_writes - base, e_writes);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    reset_n = 1'b0; start = 1'b0; seq_len = '0; emb_dim = '0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_raddr", raddr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    reset_n = 1'b1;

    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    mem[4] = 5; mem[5] = 6; mem[6] = 7; mem[7] = 8;
    exp_q.push_back({16'd12, 32'd17});
    exp_q.push_back({16'd13, 32'd23});
    exp_q.push_back({16'd14, 32'd39});
    exp_q.push_back({16'd15, 32'd53});
    run(2, 2, 17, 1'b0, 4, 1'b0);

    mem[0] = 3; mem[1] = 32'hFFFF_FFFF;
    exp_q.push_back({16'd3, 32'hFFFF_FFFD});
    run(1, 1, 4, 1'b0, 1, 1'b0);

    run(0, 5, 1, 1'b0, 0, 1'b0);
    run(3, 0, 1, 1'b0, 0, 1'b0);
    run(2, MD+1, 1, 1'b1, 0, 1'b0);

    for (int a = 0; a < 2*2*MD; a++) mem[a] = 1;
    for (int s = 0; s < 4; s++) exp_q.push_back({16'(3*2*MD + s), 32'(MD)});
    run(2, MD, 2*MD + 4*(MD+1) + 1, 1'b0, 4, 1'b0);

    fill_random(3, 5);
    push_model(3, 5);
    run(3, 5, 15 + 9*6 + 1, 1'b0, 9, 1'b1);

    fill_random(2, 3);
    push_model(2, 3);
    run(2, 3, 6 + 4*4 + 1, 1'b0, 4, 1'b0);

    tick();
    seq_len = 16'd2; emb_dim = 16'd4; start = 1'b1;
    base = n_writes;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("busy_in_kstream", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1) check("abort_no_done", done, 1'b0);
    end
    check("abort_writes", n_writes - base, 0);

    fill_random(2, 2);
    push_model(2, 2);
    run(2, 2, 17, 1'b0, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
